iomem_initiator: RTL and testbench

Single-outstanding bus master for the SoC `iomem` valid/ready interface. It accepts read/write commands on a valid/ready command port and drives `iomem_valid/addr/wdata/wstrb` toward a registered `iomem` peripheral responder. It returns read data, or a timeout error, on a valid/ready response port. Its first use is driving the LED and 14-segment register responder from a debug/test agent without the CPU.

---
 rtl/iomem_initiator.sv | 142 ++++++++++++++
 tb/tb_iomem_initiator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_initiator.sv
// ============================================================================
// Module   : iomem_initiator
// Purpose  : Single-outstanding iomem bus master with command/response ports
//            and a saturating access timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  output logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST_C = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            iomem_valid_q, iomem_valid_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      iomem_valid_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      iomem_valid_q <= iomem_valid_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    iomem_valid_d = iomem_valid_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d        = cmd_addr;
          wdata_d       = cmd_wdata;
          wstrb_d       = cmd_write ? cmd_wstrb : 4'b0000;
          iomem_valid_d = 1'b1;
          cnt_d         = '0;
          state_d       = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ready is checked first so a ready arriving in the timeout cycle wins.
        if (iomem_ready) begin
          rsp_rdata_d   = iomem_rdata;
          rsp_error_d   = 1'b0;
          iomem_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST_C)) begin
          rsp_rdata_d   = ERR_DATA;
          rsp_error_d   = 1'b1;
          iomem_valid_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign iomem_valid = iomem_valid_q;
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;

endmodule

`default_nettype wire

// File: tb/tb_iomem_initiator.sv
// ============================================================================
// Module   : tb_iomem_initiator
// Purpose  : Randomized self-checking bench for iomem_initiator with a
//            transaction-level reference model and a latency-programmable responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iomem_initiator;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_rdata = '0;
  logic        busy;

  iomem_initiator #(
    .TIMEOUT_CYCLES(TO),
    .ERR_DATA      (ERR)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_wstrb(iomem_wstrb),
    .iomem_rdata(iomem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: raises ready for one cycle when valid has been high resp_lat cycles (0 = never).
  logic [31:0] resp_mem [8];
  int          resp_lat   = 0;
  int          vcyc       = 0;
  bit          late_pulse = 1'b0;

  always @(negedge clk) begin
    if (iomem_valid) vcyc = vcyc + 1;
    else             vcyc = 0;
    iomem_ready = late_pulse || (iomem_valid && resp_lat != 0 && vcyc == resp_lat);
    late_pulse  = 1'b0;
    iomem_rdata = iomem_ready ? resp_mem[iomem_addr[4:2]] : $urandom();
  end

  always @(posedge clk) begin
    if (iomem_valid && iomem_ready) begin
      for (int b = 0; b < 4; b++)
        if (iomem_wstrb[b]) resp_mem[iomem_addr[4:2]][8*b +: 8] = iomem_wdata[8*b +: 8];
    end
  end

  // Reference model: expected bus view and response of one transaction.
  logic [31:0] ref_mem [8];

  task automatic ref_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input int lat, output int dur,
                         output logic err, output logic [31:0] rd, output logic [3:0] bws);
    bws = wr ? ws : 4'b0000;
    if (lat != 0 && lat <= int'(TO)) begin
      dur = lat;
      err = 1'b0;
      rd  = ref_mem[a[4:2]];
      for (int b = 0; b < 4; b++)
        if (bws[b]) ref_mem[a[4:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      dur = int'(TO);
      err = 1'b1;
      rd  = ERR;
    end
  endtask

  int prev_acc = 0;
  int prev_dur = 0;

  // Entered and left at a falling edge with the block idle.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int lat, input int hold,
                     input bit chain, input bit late);
    int          dur, nv, bus_bad, hold_bad, acc;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  bws;
    ref_txn(wr, a, wd, ws, lat, dur, err, rd, bws);
    check_eq("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
    resp_lat  = lat;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    cmd_wdata = $urandom();
    if (chain) check_eq("accept_spacing", acc - prev_acc, prev_dur + 2);
    nv = 0; bus_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!iomem_valid) break;
      nv++;
      if (iomem_addr !== a || iomem_wdata !== wd || iomem_wstrb !== bws ||
          cmd_ready !== 1'b0 || busy !== 1'b1) bus_bad++;
    end
    check_eq("valid_cycles", nv, dur);
    check_eq("bus_view", bus_bad, 0);
    check_eq("rsp_valid_rise", {31'd0, rsp_valid}, 32'd1);
    check_eq("rsp_rdata", rsp_rdata, rd);
    check_eq("rsp_error", {31'd0, rsp_error}, {31'd0, err});
    if (hold > 0) begin
      rsp_ready = 1'b0;
      cmd_addr  = 32'h1C;
      cmd_valid = 1'b1;
      hold_bad  = 0;
      for (int k = 0; k < hold; k++) begin
        if (late && k == 1) late_pulse = 1'b1;
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_error !== err ||
            cmd_ready !== 1'b0 || iomem_valid !== 1'b0) hold_bad++;
      end
      check_eq("rsp_hold_stable", hold_bad, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("rsp_consumed", {30'd0, rsp_valid, iomem_valid}, 32'd0);
    check_eq("back_to_idle", {30'd0, cmd_ready, busy}, 32'd2);
    prev_acc = acc;
    prev_dur = dur;
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 8; i++) begin
      resp_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    resp_mem[5] = 32'hC0FFEE05;
    ref_mem[5]  = 32'hC0FFEE05;

    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {26'd0, iomem_valid, rsp_valid, rsp_error, busy, cmd_ready, 1'b0}, 32'd2);
    check_eq("reset_addr", iomem_addr, 32'd0);
    check_eq("reset_wdata", iomem_wdata, 32'd0);
    check_eq("reset_wstrb", {28'd0, iomem_wstrb}, 32'd0);
    check_eq("reset_rdata", rsp_rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Read with single-cycle responder, then partial write and read-back.
    txn(1'b0, 32'h14, 32'h12345678, 4'hF, 1, 0, 1'b0, 1'b0);
    txn(1'b1, 32'h00, 32'hA5A5A5A5, 4'b0001, 2, 0, 1'b0, 1'b0);
    check_eq("partial_write_reg", resp_mem[0], 32'h000000A5);
    txn(1'b0, 32'h00, 32'h0, 4'h0, 1, 0, 1'b0, 1'b0);

    // Timeout with a late ready pulse during response backpressure, then one in idle.
    txn(1'b0, 32'h08, 32'h0, 4'h0, 0, 6, 1'b0, 1'b1);
    late_pulse = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    check_eq("late_ready_idle", bad, 0);

    // Ready arriving in the same cycle the timeout would fire.
    txn(1'b0, 32'h14, 32'h0, 4'h0, int'(TO), 0, 1'b0, 1'b0);
    // Write with zero strobes goes out as a read.
    txn(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 3, 0, 1'b0, 1'b0);
    // Response backpressure for 10 cycles.
    txn(1'b0, 32'h14, 32'h0, 4'h0, 2, 10, 1'b0, 1'b0);

    // Back-to-back commands with rsp_ready tied high.
    for (int i = 0; i < 8; i++)
      txn(1'($urandom_range(0, 1)), {27'd0, 3'($urandom_range(0, 7)), 2'b00},
          $urandom(), 4'($urandom_range(0, 15)), 1, 0, (i > 0), 1'b0);

    // Randomized mix of latencies, timeouts and backpressure.
    for (int i = 0; i < 24; i++)
      txn(1'($urandom_range(0, 1)), {27'd0, 3'($urandom_range(0, 7)), 2'b00},
          $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 6),
          $urandom_range(0, 2), 1'b0, 1'b0);

    // Reset while the bus request is pending.
    cmd_write = 1'b0; cmd_addr = 32'h08; resp_lat = 0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #3;
    check_eq("pre_reset_valid", {31'd0, iomem_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("async_reset_ctrl", {29'd0, iomem_valid, rsp_valid, busy}, 32'd0);
    check_eq("async_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("async_reset_addr", iomem_addr, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || iomem_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    check_eq("post_reset_quiet", bad, 0);
    txn(1'b0, 32'h14, 32'h0, 4'h0, 1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
